// File: rtl/wsa_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wsa_pkg                                                          |
// | Shared FSM encoding and reset divisor for write_slot_arbiter.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package wsa_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;

   localparam int WSA_DEFAULT_DIV = 2047;

endpackage : wsa_pkg
`default_nettype wire

// File: rtl/wsa_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wsa_tick_gen                                                     |
// | Programmable slot counter producing one TICK per divisor period. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module wsa_tick_gen
   import wsa_pkg::*;
#(
   parameter int DIV_WIDTH = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DIV_WIDTH-1:0] div_value,
   input  logic                 div_load,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] div_reg;
   logic [DIV_WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_reg <= DIV_WIDTH'(WSA_DEFAULT_DIV);
         count   <= '0;
      end else if (div_load) begin
         div_reg <= div_value;
         count   <= '0;
      end else if (count == div_reg) begin
         count   <= '0;
      end else begin
         count   <= count + 1'b1;
      end
   end

   // A reload restarts the period, so the edge that loads must not also fire.
   assign tick = (count == div_reg) && !div_load;

endmodule : wsa_tick_gen
`default_nettype wire

// File: rtl/write_slot_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | write_slot_arbiter                                               |
// | Round-robin arbiter granting one shared write per slot tick.     |
// | Option macro: WRITE_SLOT_ARBITER_PRIORITY_EN (requester 0 fixed  |
// | priority).                                                       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module write_slot_arbiter
   import wsa_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 11
) (
   input  logic                          IN_50Mhz,
   input  logic                          RST_N,
   input  logic [DIV_WIDTH-1:0]          DIV_VALUE,
   input  logic                          DIV_LOAD,
   input  logic [NUM_REQ-1:0]            REQ,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]            GNT,
   output logic                          WR_EN,
   output logic [DATA_WIDTH-1:0]         WR_DATA,
   output logic [$clog2(NUM_REQ)-1:0]    WR_OWNER,
   output logic                          BUSY
);

   localparam int OW = $clog2(NUM_REQ);

   logic [1:0]            state;
   logic [1:0]            state_next;
   logic [OW-1:0]         rr_ptr;
   logic [OW-1:0]         ptr_next;
   logic [OW-1:0]         winner;
   logic [OW:0]           cand_sum;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  tick;
   logic                  start;

   wsa_tick_gen #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_tick_gen (
      .clk       (IN_50Mhz),
      .rst_n     (RST_N),
      .div_value (DIV_VALUE),
      .div_load  (DIV_LOAD),
      .tick      (tick)
   );

   assign start = (state == IDLE) && tick && (|REQ);

   // Scan downward so the candidate closest to rr_ptr is the last one kept.
   always_comb begin
      winner   = '0;
      cand_sum = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand_sum = {1'b0, rr_ptr} + (OW + 1)'(i);
         if (cand_sum >= (OW + 1)'(NUM_REQ)) begin
            cand_sum = cand_sum - (OW + 1)'(NUM_REQ);
         end
         if (REQ[cand_sum[OW-1:0]]) begin
            winner = cand_sum[OW-1:0];
         end
      end
`ifdef WRITE_SLOT_ARBITER_PRIORITY_EN
      if (REQ[0]) begin
         winner = '0;
      end
`endif
   end

   always_comb begin
      if (winner == OW'(NUM_REQ - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = winner + 1'b1;
      end
`ifdef WRITE_SLOT_ARBITER_PRIORITY_EN
      if (REQ[0]) begin
         ptr_next = rr_ptr;
      end
`endif
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == OW'(i)) begin
            win_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge IN_50Mhz) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = GRANT;
         GRANT:   state_next = WRITE;
         WRITE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      GNT   = '0;
      WR_EN = (state == WRITE);
      BUSY  = (state == GRANT) || (state == WRITE);
      if (state == GRANT) begin
         GNT[WR_OWNER] = 1'b1;
      end
   end

   // Winner is captured at the tick so later REQ changes cannot disturb the slot.
   always_ff @(posedge IN_50Mhz) begin
      if (!RST_N) begin
         rr_ptr   <= '0;
         WR_OWNER <= '0;
         WR_DATA  <= '0;
      end else if (start) begin
         rr_ptr   <= ptr_next;
         WR_OWNER <= winner;
         WR_DATA  <= win_data;
      end
   end

endmodule : write_slot_arbiter
`default_nettype wire

// File: tb/tb_write_slot_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_write_slot_arbiter                                            |
// | Directed, table-driven bench for write_slot_arbiter.             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_write_slot_arbiter;

   typedef struct {
      logic [3:0] req;
      logic [3:0] exp_gnt;
      logic [1:0] exp_owner;
      logic [7:0] exp_data;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] div_value;
   logic        div_load;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic [1:0]  wr_owner;
   logic        busy;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;

   vec_t vecs[10];
   vec_t pvecs[4];

   write_slot_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (8),
      .DIV_WIDTH  (11)
   ) dut (
      .IN_50Mhz  (clk),
      .RST_N     (rst_n),
      .DIV_VALUE (div_value),
      .DIV_LOAD  (div_load),
      .REQ       (req),
      .REQ_DATA  (req_data),
      .GNT       (gnt),
      .WR_EN     (wr_en),
      .WR_DATA   (wr_data),
      .WR_OWNER  (wr_owner),
      .BUSY      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_gnt(input int limit, output bit ok);
      int n = 0;
      while (gnt == 4'b0000 && n < limit) begin
         @(negedge clk);
         n++;
      end
      ok = (gnt != 4'b0000);
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL gnt_timeout actual=none required=grant within %0d cycles", limit);
      end
   endtask

   // Leaves RST_N low after two reset edges, at a negedge.
   task automatic reset_hold();
      @(negedge clk);
      rst_n    = 1'b0;
      div_load = 1'b0;
      req      = 4'b0000;
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gnt"},   32'(gnt),      32'h0);
      chk({tag, "_wr_en"}, 32'(wr_en),    32'h0);
      chk({tag, "_data"},  32'(wr_data),  32'h0);
      chk({tag, "_owner"}, 32'(wr_owner), 32'h0);
      chk({tag, "_busy"},  32'(busy),     32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  start_cyc;
      int  prev_cyc;
      int  gcount;
      bit  ok;

      rst_n     = 1'b0;
      div_value = '0;
      div_load  = 1'b0;
      req       = 4'b0000;
      req_data  = 32'hD3C2B1A0;

      vecs[0] = '{4'b1111, 4'b0001, 2'd0, 8'hA0};
`ifdef WRITE_SLOT_ARBITER_PRIORITY_EN
      vecs[1] = '{4'b1111, 4'b0001, 2'd0, 8'hA0};
      vecs[2] = '{4'b1111, 4'b0001, 2'd0, 8'hA0};
      vecs[3] = '{4'b1111, 4'b0001, 2'd0, 8'hA0};
      vecs[4] = '{4'b1111, 4'b0001, 2'd0, 8'hA0};
      vecs[5] = '{4'b0100, 4'b0100, 2'd2, 8'hC2};
      vecs[6] = '{4'b0011, 4'b0001, 2'd0, 8'hA0};
      vecs[7] = '{4'b1010, 4'b1000, 2'd3, 8'hD3};
      vecs[8] = '{4'b1001, 4'b0001, 2'd0, 8'hA0};
      vecs[9] = '{4'b1000, 4'b1000, 2'd3, 8'hD3};
      pvecs[0] = '{4'b1001, 4'b0001, 2'd0, 8'hA0};
      pvecs[1] = '{4'b1001, 4'b0001, 2'd0, 8'hA0};
      pvecs[2] = '{4'b1001, 4'b0001, 2'd0, 8'hA0};
      pvecs[3] = '{4'b1001, 4'b0001, 2'd0, 8'hA0};
`else
      vecs[1] = '{4'b1111, 4'b0010, 2'd1, 8'hB1};
      vecs[2] = '{4'b1111, 4'b0100, 2'd2, 8'hC2};
      vecs[3] = '{4'b1111, 4'b1000, 2'd3, 8'hD3};
      vecs[4] = '{4'b1111, 4'b0001, 2'd0, 8'hA0};
      vecs[5] = '{4'b0100, 4'b0100, 2'd2, 8'hC2};
      vecs[6] = '{4'b0011, 4'b0001, 2'd0, 8'hA0};
      vecs[7] = '{4'b1010, 4'b0010, 2'd1, 8'hB1};
      vecs[8] = '{4'b1001, 4'b1000, 2'd3, 8'hD3};
      vecs[9] = '{4'b1000, 4'b1000, 2'd3, 8'hD3};
      pvecs[0] = '{4'b1001, 4'b0001, 2'd0, 8'hA0};
      pvecs[1] = '{4'b1001, 4'b1000, 2'd3, 8'hD3};
      pvecs[2] = '{4'b1001, 4'b0001, 2'd0, 8'hA0};
      pvecs[3] = '{4'b1001, 4'b1000, 2'd3, 8'hD3};
`endif

      // Reset values, then the default divisor: first grant in cycle 2049.
      reset_hold();
      chk_reset_outputs("reset");
      rst_n     = 1'b1;
      req       = 4'b0001;
      start_cyc = cyc;
      wait_gnt(2100, ok);
      if (ok) begin
         chk("first_gnt_cycle", 32'(cyc - start_cyc + 1), 32'd2049);
         chk("first_gnt",       32'(gnt),   32'h1);
         chk("first_gnt_wr_en", 32'(wr_en), 32'h0);
         chk("first_gnt_busy",  32'(busy),  32'h1);
         @(negedge clk);
         chk("first_wr_cycle",  32'(cyc - start_cyc + 1), 32'd2050);
         chk("first_wr_en",     32'(wr_en),   32'h1);
         chk("first_wr_data",   32'(wr_data), 32'hA0);
         @(negedge clk);
         chk("first_idle_busy", 32'(busy),    32'h0);
         chk("first_hold_data", 32'(wr_data), 32'hA0);
      end

      // Divisor 5: table of grants, one slot every 6 cycles.
      reset_hold();
      rst_n     = 1'b1;
      div_value = 11'd5;
      div_load  = 1'b1;
      req       = vecs[0].req;
      @(negedge clk);
      div_load  = 1'b0;
      prev_cyc  = cyc;
      for (int i = 0; i < 10; i++) begin
         req = vecs[i].req;
         wait_gnt(20, ok);
         if (ok) begin
            chk($sformatf("v%0d_gap",   i), 32'(cyc - prev_cyc), 32'd6);
            chk($sformatf("v%0d_gnt",   i), 32'(gnt),      32'(vecs[i].exp_gnt));
            chk($sformatf("v%0d_owner", i), 32'(wr_owner), 32'(vecs[i].exp_owner));
            chk($sformatf("v%0d_data",  i), 32'(wr_data),  32'(vecs[i].exp_data));
            prev_cyc = cyc;
            @(negedge clk);
            chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'h1);
            chk($sformatf("v%0d_wr_gnt", i), 32'(gnt), 32'h0);
         end
      end

      // Divisor 0: intermediate ticks are dropped, so one write every 3 cycles.
      reset_hold();
      rst_n     = 1'b1;
      div_value = 11'd0;
      div_load  = 1'b1;
      req       = 4'b0010;
      @(negedge clk);
      div_load  = 1'b0;
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("div0_wr_en_k%0d", k), 32'(wr_en), ((k % 3) == 2) ? 32'h1 : 32'h0);
         @(negedge clk);
      end
      chk("div0_owner", 32'(wr_owner), 32'h1);
      chk("div0_data",  32'(wr_data),  32'hB1);

      // Reset in the GRANT cycle, together with a DIV_LOAD that must lose.
      wait_gnt(10, ok);
      if (ok) begin
         rst_n     = 1'b0;
         div_load  = 1'b1;
         div_value = 11'd7;
         @(negedge clk);
         chk_reset_outputs("midreset");
         rst_n    = 1'b1;
         div_load = 1'b0;
         gcount   = 0;
         for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (gnt != 4'b0000 || wr_en) gcount++;
         end
         chk("midreset_div_default", 32'(gcount), 32'h0);
      end

      // Divisor 3 with requesters 0 and 3 held.
      reset_hold();
      rst_n     = 1'b1;
      div_value = 11'd3;
      div_load  = 1'b1;
      req       = 4'b1001;
      @(negedge clk);
      div_load  = 1'b0;
      prev_cyc  = cyc;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(10, ok);
         if (ok) begin
            chk($sformatf("p%0d_gap", i), 32'(cyc - prev_cyc), 32'd4);
            chk($sformatf("p%0d_gnt", i), 32'(gnt), 32'(pvecs[i].exp_gnt));
            prev_cyc = cyc;
            req = 4'b0000;
            @(negedge clk);
            chk($sformatf("p%0d_wr_en", i), 32'(wr_en),   32'h1);
            chk($sformatf("p%0d_data",  i), 32'(wr_data), 32'(pvecs[i].exp_data));
            req = 4'b1001;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_write_slot_arbiter
`default_nettype wire
